// File: rtl/ec_key_serdes_pkg.sv
// Shared types and SEC1 constants for the EC key byte-stream codec.
package ec_key_pkg;

  typedef enum logic [1:0] {
    OP_IMPORT     = 2'd0,
    OP_EXP_SCALAR = 2'd1,
    OP_EXP_UNCOMP = 2'd2,
    OP_EXP_COMP   = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ERR_OK    = 3'd0,
    ERR_LEN   = 3'd1,
    ERR_ZERO  = 3'd2,
    ERR_RANGE = 3'd3,
    ERR_NOKEY = 3'd4,
    ERR_CFG   = 3'd5
  } err_e;

  typedef enum logic [2:0] {
    ST_IDLE, ST_IMPORT, ST_DRAIN, ST_EXPORT, ST_FIN
  } state_e;

  localparam logic [7:0] SEC1_UNCOMP    = 8'h04;
  localparam logic [7:0] SEC1_COMP_EVEN = 8'h02;
  localparam logic [7:0] SEC1_COMP_ODD  = 8'h03;

endpackage

// File: rtl/ec_key_serdes_if.sv
// Host-side command, import stream and export stream handshakes.
interface ec_key_serdes_if;
  import ec_key_pkg::*;

  logic       cmd_valid;
  logic       cmd_ready;
  op_e        cmd_op;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       s_last;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_last;

  modport master (
    output cmd_valid, cmd_op, s_valid, s_data, s_last, m_ready,
    input  cmd_ready, s_ready, m_valid, m_data, m_last
  );

  modport slave (
    input  cmd_valid, cmd_op, s_valid, s_data, s_last, m_ready,
    output cmd_ready, s_ready, m_valid, m_data, m_last
  );
endinterface

// File: rtl/ec_bytecmp_msb.sv
// Streaming MSB-first magnitude compare of a byte stream against a reference,
// plus a sticky nonzero flag over the stream.
module ec_bytecmp_msb (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       beat_en,
  input  logic [7:0] a_byte,
  input  logic [7:0] b_byte,
  output logic       lt,
  output logic       eq,
  output logic       gt,
  output logic       nonzero
);
  logic lt_q, gt_q, nz_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lt_q <= 1'b0;
      gt_q <= 1'b0;
      nz_q <= 1'b0;
    end else if (clear) begin
      lt_q <= 1'b0;
      gt_q <= 1'b0;
      nz_q <= 1'b0;
    end else if (beat_en) begin
      // once a byte differs the verdict is frozen
      if (!lt_q && !gt_q) begin
        lt_q <= a_byte < b_byte;
        gt_q <= a_byte > b_byte;
      end
      nz_q <= nz_q | (a_byte != 8'h00);
    end
  end

  assign lt      = lt_q;
  assign gt      = gt_q;
  assign eq      = !lt_q && !gt_q;
  assign nonzero = nz_q;
endmodule

// File: rtl/ec_key_serdes.sv
// EC key codec: range-checked scalar import into the key register, and
// scalar / SEC1 point export, over byte streams.
module ec_key_serdes
  import ec_key_pkg::*;
#(
  parameter int MAX_KEY_BYTES = 66,
  parameter int LW            = $clog2(MAX_KEY_BYTES + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [LW-1:0]              cfg_key_bytes,
  input  logic [8*MAX_KEY_BYTES-1:0] cfg_order,
  ec_key_serdes_if.slave             bus,
  input  logic [8*MAX_KEY_BYTES-1:0] pt_x,
  input  logic [8*MAX_KEY_BYTES-1:0] pt_y,
  output logic [8*MAX_KEY_BYTES-1:0] key_scalar,
  output logic                       key_valid,
  output logic                       done,
  output logic [2:0]                 err
);
  localparam int KW = 8 * MAX_KEY_BYTES;
  localparam int EW = $clog2(2 * MAX_KEY_BYTES + 2);

  function automatic logic [7:0] byte_at(input logic [KW-1:0] v, input logic [EW-1:0] idx);
    logic [KW-1:0] sh;
    sh = v >> {idx, 3'b000};
    return sh[7:0];
  endfunction

  state_e          state_q, state_d;
  op_e             op_q;
  err_e            pend_q, err_q, fin_err;
  logic [LW-1:0]   len_q, cnt_q;
  logic [EW-1:0]   ecnt_q, lz, flen;
  logic [KW-1:0]   shadow_q, key_q;
  logic            kv_q;
  logic            accept, cfg_bad, last_in, exp_last;
  logic [7:0]      ord_byte, exp_byte;
  logic            cmp_lt, cmp_eq, cmp_gt, cmp_nz;
  logic            cmd_ready_w, s_ready_w, m_valid_w, m_last_w;
  logic [7:0]      m_data_w;

  assign accept   = bus.cmd_valid && (state_q == ST_IDLE);
  assign cfg_bad  = (cfg_key_bytes == '0) || (cfg_key_bytes > LW'(MAX_KEY_BYTES));
  assign last_in  = cnt_q == (len_q - LW'(1));
  assign lz       = EW'(len_q);
  assign ord_byte = byte_at(cfg_order, EW'(len_q - cnt_q - LW'(1)));

  ec_bytecmp_msb u_cmp (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept),
    .beat_en ((state_q == ST_IMPORT) && bus.s_valid),
    .a_byte  (bus.s_data),
    .b_byte  (ord_byte),
    .lt      (cmp_lt),
    .eq      (cmp_eq),
    .gt      (cmp_gt),
    .nonzero (cmp_nz)
  );

  always_comb begin
    flen     = lz;
    exp_byte = 8'h00;
    case (op_q)
      OP_EXP_SCALAR: exp_byte = byte_at(key_q, lz - ecnt_q - EW'(1));
      OP_EXP_UNCOMP: begin
        flen = (lz << 1) + EW'(1);
        if (ecnt_q == '0)      exp_byte = SEC1_UNCOMP;
        else if (ecnt_q <= lz) exp_byte = byte_at(pt_x, lz - ecnt_q);
        else                   exp_byte = byte_at(pt_y, (lz << 1) - ecnt_q);
      end
      OP_EXP_COMP: begin
        flen = lz + EW'(1);
        if (ecnt_q == '0) exp_byte = pt_y[0] ? SEC1_COMP_ODD : SEC1_COMP_EVEN;
        else              exp_byte = byte_at(pt_x, lz - ecnt_q);
      end
      default: exp_byte = 8'h00;
    endcase
  end

  assign exp_last = ecnt_q == (flen - EW'(1));

  // LEN/CFG/NOKEY are known early; ZERO/RANGE only once the last byte is in
  always_comb begin
    fin_err = pend_q;
    if (pend_q == ERR_OK && op_q == OP_IMPORT) begin
      if (!cmp_nz)                 fin_err = ERR_ZERO;
      else if (cmp_eq || cmp_gt)   fin_err = ERR_RANGE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    cmd_ready_w = 1'b0;
    s_ready_w   = 1'b0;
    m_valid_w   = 1'b0;
    m_data_w    = 8'h00;
    m_last_w    = 1'b0;
    done        = 1'b0;
    err         = err_q;
    case (state_q)
      ST_IDLE: begin
        cmd_ready_w = 1'b1;
        if (bus.cmd_valid) begin
          if (cfg_bad || (bus.cmd_op == OP_EXP_SCALAR && !kv_q)) state_d = ST_FIN;
          else if (bus.cmd_op == OP_IMPORT)                      state_d = ST_IMPORT;
          else                                                   state_d = ST_EXPORT;
        end
      end
      ST_IMPORT: begin
        s_ready_w = 1'b1;
        if (bus.s_valid) begin
          if (bus.s_last)   state_d = ST_FIN;
          else if (last_in) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        s_ready_w = 1'b1;
        if (bus.s_valid && bus.s_last) state_d = ST_FIN;
      end
      ST_EXPORT: begin
        m_valid_w = 1'b1;
        m_data_w  = exp_byte;
        m_last_w  = exp_last;
        if (bus.m_ready && exp_last) state_d = ST_FIN;
      end
      ST_FIN: begin
        done    = 1'b1;
        err     = fin_err;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= OP_IMPORT;
      pend_q   <= ERR_OK;
      err_q    <= ERR_OK;
      len_q    <= '0;
      cnt_q    <= '0;
      ecnt_q   <= '0;
      shadow_q <= '0;
      key_q    <= '0;
      kv_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (accept) begin
          op_q     <= bus.cmd_op;
          len_q    <= cfg_key_bytes;
          cnt_q    <= '0;
          ecnt_q   <= '0;
          shadow_q <= '0;
          if (cfg_bad)                                     pend_q <= ERR_CFG;
          else if (bus.cmd_op == OP_EXP_SCALAR && !kv_q)   pend_q <= ERR_NOKEY;
          else                                             pend_q <= ERR_OK;
        end
        ST_IMPORT: if (bus.s_valid) begin
          shadow_q <= {shadow_q[KW-9:0], bus.s_data};
          cnt_q    <= cnt_q + LW'(1);
          // s_last early (short) or missing at byte L (long) are both LEN
          if (bus.s_last != last_in) pend_q <= ERR_LEN;
        end
        ST_EXPORT: if (bus.m_ready) ecnt_q <= ecnt_q + EW'(1);
        ST_FIN: begin
          err_q    <= fin_err;
          shadow_q <= '0;
          if (op_q == OP_IMPORT && fin_err == ERR_OK) begin
            key_q <= shadow_q;
            kv_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_w && !rst;
  assign bus.s_ready   = s_ready_w;
  assign bus.m_valid   = m_valid_w;
  assign bus.m_data    = m_data_w;
  assign bus.m_last    = m_last_w;
  assign key_scalar    = key_q;
  assign key_valid     = kv_q;
endmodule
